// File: rtl/bcd_serial_pkg.sv
// Shared constants, types and frame builder for the serial BCD ALU host.
package bcd_serial_pkg;

  localparam int unsigned OPND_W         = 16;
  localparam int unsigned HDR_W          = 8;
  localparam int unsigned REQ_FRAME_BITS = 41;
  localparam int unsigned RSP_DATA_BITS  = 20;

  localparam logic [HDR_W-1:0] REQ_HDR = 8'h5A;
  localparam logic [HDR_W-1:0] RSP_HDR = 8'h69;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_FLUSH    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SEND     = 3'd2,
    ST_WAIT_HDR = 3'd3,
    ST_RECV     = 3'd4
  } state_e;

  typedef struct packed {
    logic              op;
    logic [OPND_W-1:0] a;
    logic [OPND_W-1:0] b;
  } req_t;

  // Bit 0 of the result is the first bit on the wire; operands go out MSB-first.
  function automatic logic [REQ_FRAME_BITS-1:0] build_frame(input req_t req);
    logic [OPND_W-1:0] a_rev;
    logic [OPND_W-1:0] b_rev;
    a_rev = {<<{req.a}};
    b_rev = {<<{req.b}};
    return {b_rev, a_rev, req.op, REQ_HDR};
  endfunction

endpackage

// File: rtl/bcd_serial_deframer.sv
// Response header matcher and 20-bit result collector for the ALU result line.
module bcd_serial_deframer
  import bcd_serial_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     hdr_en,
  input  logic                     data_en,
  input  logic                     ser_rx,
  output logic                     hdr_match_c,
  output logic                     done_c,
  output logic [RSP_DATA_BITS-1:0] data_c
);

  localparam int unsigned CNT_W = $clog2(RSP_DATA_BITS + 1);

  logic [HDR_W-1:0]         hdr_q;
  logic [HDR_W-1:0]         hdr_next_c;
  logic [RSP_DATA_BITS-2:0] col_q;
  logic [CNT_W-1:0]         cnt_q;

  // Header arrives LSB-first, so new bits enter at the top.
  assign hdr_next_c  = {ser_rx, hdr_q[HDR_W-1:1]};
  assign hdr_match_c = hdr_en && (hdr_next_c == RSP_HDR);
  assign data_c      = {col_q, ser_rx};
  assign done_c      = data_en && (cnt_q == CNT_W'(RSP_DATA_BITS - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      hdr_q <= '0;
      col_q <= '0;
      cnt_q <= '0;
    end else if (hdr_en) begin
      hdr_q <= hdr_next_c;
    end else if (data_en) begin
      col_q <= data_c[RSP_DATA_BITS-2:0];
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/bcd_serial_host.sv
// Host side of the serial BCD ALU: serializes one request, then deserializes the result.
module bcd_serial_host
  import bcd_serial_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 32,
  parameter int unsigned FLUSH_CYCLES   = 41
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_op,
  input  logic [OPND_W-1:0]        req_a,
  input  logic [OPND_W-1:0]        req_b,
  output logic                     ser_tx,
  input  logic                     ser_rx,
  output logic                     rsp_valid,
  output logic [RSP_DATA_BITS-1:0] rsp_data,
  output logic                     rsp_timeout
);

  localparam int unsigned MAX_TF  = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
  localparam int unsigned CNT_MAX = (REQ_FRAME_BITS > MAX_TF) ? REQ_FRAME_BITS : MAX_TF;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [REQ_FRAME_BITS-2:0] tx_sr_q, tx_sr_d;
  logic                      ser_tx_d;
  logic                      req_ready_d;
  logic                      rsp_valid_d;
  logic                      rsp_timeout_d;
  logic [RSP_DATA_BITS-1:0]  rsp_data_d;

  req_t                      req_c;
  logic [REQ_FRAME_BITS-1:0] frame_c;
  logic                      dfr_clear_c;
  logic                      hdr_en_c;
  logic                      data_en_c;
  logic                      hdr_match_c;
  logic                      done_c;
  logic [RSP_DATA_BITS-1:0]  data_c;

  assign req_c   = {req_op, req_a, req_b};
  assign frame_c = build_frame(req_c);

  bcd_serial_deframer u_deframer (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (dfr_clear_c),
    .hdr_en      (hdr_en_c),
    .data_en     (data_en_c),
    .ser_rx      (ser_rx),
    .hdr_match_c (hdr_match_c),
    .done_c      (done_c),
    .data_c      (data_c)
  );

  // Next-state and next-output logic; one shared counter serves flush, send and wait.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tx_sr_d       = tx_sr_q;
    ser_tx_d      = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_data_d    = rsp_data;
    dfr_clear_c   = 1'b0;
    hdr_en_c      = 1'b0;
    data_en_c     = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          ser_tx_d = frame_c[0];
          tx_sr_d  = frame_c[REQ_FRAME_BITS-1:1];
          cnt_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (cnt_q == CNT_W'(REQ_FRAME_BITS - 1)) begin
          state_d     = ST_WAIT_HDR;
          cnt_d       = '0;
          dfr_clear_c = 1'b1;
        end else begin
          ser_tx_d = tx_sr_q[0];
          tx_sr_d  = {1'b0, tx_sr_q[REQ_FRAME_BITS-2:1]};
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_HDR: begin
        hdr_en_c = 1'b1;
        if (hdr_match_c) begin
          state_d = ST_RECV;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RECV: begin
        data_en_c = 1'b1;
        if (done_c) begin
          rsp_data_d  = data_c;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_FLUSH;
        cnt_d   = '0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= '0;
      tx_sr_q     <= '0;
      ser_tx      <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_data    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_sr_q     <= tx_sr_d;
      ser_tx      <= ser_tx_d;
      req_ready   <= req_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_data    <= rsp_data_d;
    end
  end

endmodule
